// File: rtl/lebug_cfg_pkg.sv
// Shared definitions for the LEBUG configuration broadcast path: transmitter
// states, the unowned config id and the per-block config ids.
package lebug_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } txState_e;

  localparam logic [7:0] IDLE_CONFIG_ID = 8'hFF;

  localparam logic [7:0] CFG_ID_TRIGGER  = 8'h00;
  localparam logic [7:0] CFG_ID_FILTER   = 8'h01;
  localparam logic [7:0] CFG_ID_COUNTER  = 8'h02;
  localparam logic [7:0] CFG_ID_MATCHER  = 8'h03;
  localparam logic [7:0] CFG_ID_SEQUENCE = 8'h04;
  localparam logic [7:0] CFG_ID_OUTPUT   = 8'h05;

  // A frame is only sendable if the whole thing fits in the byte buffer at once.
  function automatic logic frameFits(input logic [7:0] numBytes, input int depth);
    return int'(numBytes) <= depth;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte buffer with an occupancy count.
// A push into a full buffer is taken when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  always_comb begin
    doPop  = pop_i && (count_q != '0);
    doPush = push_i && ((count_q < FULL_CNT) || doPop);
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/config_transmitter.sv
// Broadcasts configuration frames to the building blocks: drops tracing, waits
// for the pipelines to drain, then streams a buffered frame followed by a gap.
module config_transmitter #(
  parameter int         FIFO_DEPTH     = 32,
  parameter int         MAX_CHAINS     = 4,
  parameter int         DRAIN_CYCLES   = 3,
  parameter logic [7:0] IDLE_CONFIG_ID = lebug_cfg_pkg::IDLE_CONFIG_ID
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tracing_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_config_id,
  input  logic [7:0] cmd_num_bytes,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] byte_data,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import lebug_cfg_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  if ((FIFO_DEPTH < 5 * MAX_CHAINS) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadParams
    $error("config_transmitter: FIFO_DEPTH must be a power of two and at least 5*MAX_CHAINS");
  end

  txState_e      state_q;
  txState_e      state_d;
  logic [DW-1:0] drainCnt_q;
  logic [DW-1:0] drainCnt_d;
  logic [7:0]    remaining_q;
  logic [7:0]    remaining_d;
  logic [7:0]    id_q;
  logic [7:0]    id_d;
  logic [7:0]    len_q;
  logic [7:0]    len_d;
  logic          tracing_q;
  logic [7:0]    configId_q;
  logic [7:0]    configData_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic          frameOk;
  logic          errNext;
  logic          pop;
  logic          push;
  logic [7:0]    fifoData;
  logic [CW-1:0] fifoCount;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (byte_data),
    .pop_i   (pop && !reset),
    .rdata_o (fifoData),
    .count_o (fifoCount)
  );

  assign cmd_ready  = (state_q == IDLE);
  assign byte_ready = (fifoCount < DEPTH_CNT);
  assign push       = byte_valid && byte_ready && !reset;

  // The byte popped on the edge into a SEND cycle is what that cycle shows,
  // so the first byte lands one cycle after WAIT sees a complete frame.
  always_comb begin
    state_d     = state_q;
    drainCnt_d  = drainCnt_q;
    remaining_d = remaining_q;
    id_d        = id_q;
    len_d       = len_q;
    pop         = 1'b0;
    errNext     = 1'b0;
    accept      = cmd_valid && cmd_ready && !reset;
    frameOk     = frameFits(cmd_num_bytes, FIFO_DEPTH);

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d  = cmd_config_id;
          len_d = cmd_num_bytes;
          if (frameOk) begin
            drainCnt_d = '0;
            if (DRAIN_CYCLES == 0) begin
              state_d = (cmd_num_bytes == 8'd0) ? GAP : WAIT;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            errNext = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == DRAIN_LAST) begin
          state_d = (len_q == 8'd0) ? GAP : WAIT;
        end else begin
          drainCnt_d = drainCnt_q + DW'(1);
        end
      end
      WAIT: begin
        if (int'(fifoCount) >= int'(len_q)) begin
          state_d     = SEND;
          pop         = 1'b1;
          remaining_d = len_q - 8'd1;
        end
      end
      SEND: begin
        if (remaining_q == 8'd0) begin
          state_d = GAP;
        end else begin
          pop         = 1'b1;
          remaining_d = remaining_q - 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drainCnt_q   <= '0;
      remaining_q  <= '0;
      id_q         <= IDLE_CONFIG_ID;
      len_q        <= '0;
      tracing_q    <= 1'b0;
      configId_q   <= IDLE_CONFIG_ID;
      configData_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drainCnt_q   <= drainCnt_d;
      remaining_q  <= remaining_d;
      id_q         <= id_d;
      len_q        <= len_d;
      // A rejected command never leaves IDLE, so it must not disturb tracing.
      tracing_q    <= tracing_req && (state_q == IDLE) && !(accept && frameOk);
      configId_q   <= pop ? id_q : IDLE_CONFIG_ID;
      configData_q <= pop ? fifoData : 8'd0;
      done_q       <= (state_d == GAP);
      err_q        <= errNext;
    end
  end

  assign tracing    = tracing_q;
  assign configId   = configId_q;
  assign configData = configData_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_config_transmitter.sv
// Self-checking bench for config_transmitter: directed frame scenarios plus a
// randomized phase, all checked against a timeline-level reference model.
module tb_config_transmitter;

  localparam int FIFO_DEPTH   = 32;
  localparam int MAX_CHAINS   = 4;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [7:0] IDLE_ID = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       tracing_req;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_config_id;
  logic [7:0] cmd_num_bytes;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  config_transmitter #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MAX_CHAINS     (MAX_CHAINS),
    .DRAIN_CYCLES   (DRAIN_CYCLES),
    .IDLE_CONFIG_ID (IDLE_ID)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tracing_req   (tracing_req),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_config_id (cmd_config_id),
    .cmd_num_bytes (cmd_num_bytes),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_data     (byte_data),
    .tracing       (tracing),
    .configId      (configId),
    .configData    (configData),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  // Reference model: buffered bytes plus the timeline of the frame in flight.
  logic [7:0] fifoModel[$];
  logic       inFrame = 1'b0;
  int         fLen, fAccept, fSend, fGap;
  logic [7:0] fId;
  logic [7:0] expId = IDLE_ID;
  logic [7:0] expData = 8'd0;
  logic       expDone = 1'b0;
  logic       expErr = 1'b0;
  logic       expTracing = 1'b0;

  int firstByteCyc = -1;
  int doneCyc = -1;
  int lastAcceptCyc = -1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advances one clock with the current inputs, updates the model and checks every output.
  task automatic applyStimulus();
    logic pushAcc, cmdAcc, cmdOk, popNow;
    int   nxt;
    nxt = cyc + 1;
    if (reset) begin
      fifoModel.delete();
      inFrame    = 1'b0;
      expId      = IDLE_ID;
      expData    = 8'd0;
      expDone    = 1'b0;
      expErr     = 1'b0;
      expTracing = 1'b0;
    end else begin
      pushAcc = byte_valid && (fifoModel.size() < FIFO_DEPTH);
      cmdAcc  = cmd_valid && !inFrame;
      cmdOk   = int'(cmd_num_bytes) <= FIFO_DEPTH;
      if (inFrame && fLen > 0 && fSend < 0 && cyc >= fAccept + DRAIN_CYCLES + 1 &&
          fifoModel.size() >= fLen) begin
        fSend = nxt;
        fGap  = nxt + fLen;
      end
      popNow = inFrame && fSend >= 0 && nxt >= fSend && nxt < fSend + fLen;
      if (popNow) begin
        expId   = fId;
        expData = fifoModel.pop_front();
      end else begin
        expId   = IDLE_ID;
        expData = 8'd0;
      end
      expDone    = inFrame && (nxt == fGap);
      expErr     = cmdAcc && !cmdOk;
      expTracing = tracing_req && !inFrame && !(cmdAcc && cmdOk);
      if (pushAcc) fifoModel.push_back(byte_data);
      if (inFrame && cyc == fGap) inFrame = 1'b0;
      if (cmdAcc && cmdOk) begin
        inFrame       = 1'b1;
        fAccept       = cyc;
        fLen          = int'(cmd_num_bytes);
        fId           = cmd_config_id;
        fSend         = -1;
        fGap          = (fLen == 0) ? cyc + DRAIN_CYCLES + 1 : -1;
        lastAcceptCyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("configId",   32'(configId),   32'(expId));
    checkOutput("configData", 32'(configData), 32'(expData));
    checkOutput("done",       32'(done),       32'(expDone));
    checkOutput("err",        32'(err),        32'(expErr));
    checkOutput("tracing",    32'(tracing),    32'(expTracing));
    checkOutput("busy",       32'(busy),       32'(inFrame));
    checkOutput("cmdReady",   32'(cmd_ready),  32'(!inFrame));
    checkOutput("byteReady",  32'(byte_ready), 32'(fifoModel.size() < FIFO_DEPTH));
    if (configId !== IDLE_ID && firstByteCyc < 0) firstByteCyc = cyc;
    if (done === 1'b1) doneCyc = cyc;
  endtask

  task automatic clearMarks();
    firstByteCyc = -1;
    doneCyc      = -1;
  endtask

  task automatic issueCmd(input logic [7:0] id, input logic [7:0] len);
    cmd_valid     = 1'b1;
    cmd_config_id = id;
    cmd_num_bytes = len;
    applyStimulus();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (inFrame && n < budget) begin
      byte_data = 8'($urandom);
      applyStimulus();
      n++;
    end
    checkOutput("frameTimeout", 32'(inFrame), 32'(0));
  endtask

  initial begin
    int n;
    int p8;
    logic willAccept;

    reset         = 1'b1;
    tracing_req   = 1'b0;
    cmd_valid     = 1'b0;
    cmd_config_id = 8'd0;
    cmd_num_bytes = 8'd0;
    byte_valid    = 1'b0;
    byte_data     = 8'd0;

    // Reset state
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst configId", 32'(configId), 32'(IDLE_ID));
    checkOutput("rst busy", 32'(busy), 32'(0));
    tracing_req = 1'b1;
    applyStimulus();
    applyStimulus();

    // Preloaded 20-byte frame for block 3
    for (int i = 1; i <= 20; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(i);
      applyStimulus();
    end
    byte_valid = 1'b0;
    clearMarks();
    issueCmd(8'd3, 8'd20);
    checkOutput("full tracingDrop", 32'(tracing), 32'(0));
    waitIdle(100);
    checkOutput("full firstByteLat", 32'(firstByteCyc - lastAcceptCyc), 32'(DRAIN_CYCLES + 2));
    checkOutput("full doneLat", 32'(doneCyc - lastAcceptCyc), 32'(DRAIN_CYCLES + 2 + 20));
    applyStimulus();
    checkOutput("full tracingBack", 32'(tracing), 32'(1));

    // Trickled 8-byte frame for block 5
    clearMarks();
    issueCmd(8'd5, 8'd8);
    p8 = 0;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      p8 = cyc;
      applyStimulus();
      byte_valid = 1'b0;
      applyStimulus();
      applyStimulus();
    end
    waitIdle(100);
    checkOutput("trickle firstByte", 32'(firstByteCyc - p8), 32'(2));
    checkOutput("trickle done", 32'(doneCyc - p8), 32'(2 + 8));

    // Zero-length frame
    clearMarks();
    issueCmd(8'd7, 8'd0);
    waitIdle(50);
    checkOutput("zero doneLat", 32'(doneCyc - lastAcceptCyc), 32'(DRAIN_CYCLES + 1));
    checkOutput("zero noByte", 32'(firstByteCyc), 32'(-1));

    // Oversized command is rejected, buffered bytes stay for the next frame
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      applyStimulus();
    end
    byte_valid = 1'b0;
    issueCmd(8'd6, 8'd40);
    checkOutput("reject errPulse", 32'(err), 32'(1));
    checkOutput("reject cmdReady", 32'(cmd_ready), 32'(1));
    checkOutput("reject tracing", 32'(tracing), 32'(1));
    applyStimulus();
    checkOutput("reject errOnce", 32'(err), 32'(0));
    issueCmd(8'd6, 8'd3);
    waitIdle(50);

    // Fill past capacity, then keep pushing while a full-size frame drains
    for (int i = 0; i < 33; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      applyStimulus();
    end
    checkOutput("fill byteReadyLow", 32'(byte_ready), 32'(0));
    issueCmd(8'd9, 8'd32);
    waitIdle(200);
    byte_valid = 1'b0;
    issueCmd(8'd10, 8'(fifoModel.size()));
    waitIdle(200);

    // Reset on the fifth byte of a frame
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      applyStimulus();
    end
    byte_valid = 1'b0;
    clearMarks();
    issueCmd(8'd2, 8'd10);
    n = 0;
    while (!(firstByteCyc >= 0 && cyc == firstByteCyc + 4) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("abort reachedByte5", 32'(n < 50), 32'(1));
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("abort configId", 32'(configId), 32'(IDLE_ID));
    checkOutput("abort tracing", 32'(tracing), 32'(0));
    checkOutput("abort busy", 32'(busy), 32'(0));
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("abort noDone", 32'(doneCyc), 32'(-1));
    for (int i = 0; i < 2; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      applyStimulus();
    end
    byte_valid = 1'b0;
    issueCmd(8'd4, 8'd2);
    waitIdle(50);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      byte_valid  = ($urandom_range(0, 2) != 0);
      byte_data   = 8'($urandom);
      tracing_req = ($urandom_range(0, 7) != 0);
      if (!cmd_valid && $urandom_range(0, 9) == 0) begin
        cmd_valid     = 1'b1;
        cmd_config_id = 8'($urandom_range(0, 15));
        cmd_num_bytes = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(33, 255))
                                                    : 8'($urandom_range(0, 32));
      end
      willAccept = cmd_valid && !inFrame && !reset;
      applyStimulus();
      if (willAccept) cmd_valid = 1'b0;
    end
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    byte_valid = 1'b1;
    waitIdle(300);
    byte_valid = 1'b0;
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
